// File: rtl/display_select_controller.sv
`default_nettype none
// ============================================================================
// Module      : display_select_controller
// Description : Page selector for the mirror display mux. A bouncing
//               "next page" button is synchronized and debounced, and each
//               debounced press steps a four-page FSM
//               (TEMP -> AVG -> INST -> MILES -> TEMP).
//               A low-fuel warning with hysteresis forces the MILES page
//               while it is active.
//               Optional feature macro: AUTO_SCROLL_EN adds a dwell timer
//               that steps the page automatically every DWELL_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module display_select_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DWELL_CYCLES    = 16,
  parameter int LOW_MILES       = 20,
  parameter int HYST            = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic [7:0] Miles_remaining,
  output logic [1:0] SS,
  output logic       sel_changed,
  output logic       low_fuel_warn
);

  // Debounce counter only ever reaches DEBOUNCE_CYCLES-1 before it is cleared.
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Thresholds are kept at 9 bits so LOW_MILES+HYST cannot wrap; a clear
  // threshold above 255 is never reached by the 8-bit input.
  localparam logic [8:0] SET_TH = 9'(LOW_MILES);
  localparam logic [8:0] CLR_TH = 9'(LOW_MILES + HYST);

  typedef enum logic [1:0] {
    TEMP  = 2'b00,
    AVG   = 2'b01,
    INST  = 2'b10,
    MILES = 2'b11
  } page_t;

  logic [1:0]      sync_q;
  logic            btn_sync;
  logic [DB_W-1:0] db_cnt;
  logic            deb_q;
  logic            deb_d;
  logic            btn_adv;
  logic            advance;
  page_t           state;
  page_t           state_next;
  logic            warn_next;
  logic [1:0]      ss_next;
  logic [8:0]      miles_ext;

  assign btn_sync  = sync_q[1];
  assign miles_ext = {1'b0, Miles_remaining};

  // Two-flop synchronizer for the asynchronous push-button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_next};
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      deb_q  <= 1'b0;
    end else if (btn_sync != deb_q) begin
      if (db_cnt == DB_LAST) begin
        deb_q  <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  // Delayed copy of the debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_d <= 1'b0;
    end else begin
      deb_d <= deb_q;
    end
  end

  // One advance event per debounced press; hold and release produce none.
  assign btn_adv = deb_q & ~deb_d;

`ifdef AUTO_SCROLL_EN
  localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYCLES - 1);

  logic [DW_W-1:0] dwell_q;
  logic            dwell_expire;

  // The dwell timer is frozen while the warning owns the display.
  assign dwell_expire = ~low_fuel_warn & (dwell_q == DW_LAST);

  // Dwell timer: restarts on a button press or on its own expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else if (btn_adv || dwell_expire) begin
      dwell_q <= '0;
    end else if (!low_fuel_warn) begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // A coincident press and expiry merge into a single step.
  assign advance = btn_adv | dwell_expire;
`else
  assign advance = btn_adv;
`endif

  // Page FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= TEMP;
    end else begin
      state <= state_next;
    end
  end

  // Page FSM next-state: step one page per advance event, wrapping at MILES.
  always_comb begin
    state_next = state;
    if (advance) begin
      case (state)
        TEMP:    state_next = AVG;
        AVG:     state_next = INST;
        INST:    state_next = MILES;
        MILES:   state_next = TEMP;
        default: state_next = TEMP;
      endcase
    end
  end

  // Warning with hysteresis, and the page the display should show next.
  always_comb begin
    warn_next = low_fuel_warn;
    if (miles_ext < SET_TH) begin
      warn_next = 1'b1;
    end else if (miles_ext >= CLR_TH) begin
      warn_next = 1'b0;
    end
    ss_next = warn_next ? 2'b11 : state_next;
  end

  // Registered outputs; sel_changed flags the first cycle of a new SS value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SS            <= 2'b00;
      sel_changed   <= 1'b0;
      low_fuel_warn <= 1'b0;
    end else begin
      SS            <= ss_next;
      sel_changed   <= (ss_next != SS);
      low_fuel_warn <= warn_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_select_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_select_controller
// Description : Self-checking bench for display_select_controller with a
//               behavioural reference model and randomized stimulus.
//               Honours AUTO_SCROLL_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_display_select_controller;

  localparam int DEB   = 4;
  localparam int DWELL = 16;
  localparam int LOWM  = 20;
  localparam int HYS   = 5;

  logic       clk;
  logic       rst_n;
  logic       btn_next;
  logic [7:0] miles;
  logic [1:0] SS;
  logic       sel_changed;
  logic       low_fuel_warn;

  int n_tests;
  int n_fail;

  // Reference model state (behavioural, integer based).
  int m_s1, m_s2;       // last two button samples (m_s2 older)
  int m_deb;            // accepted button level
  int m_run;            // length of the current disagreeing run
  int m_pend;           // press accepted; page steps on the next edge
  int m_page;           // page number 0..3
  int m_dwell;          // cycles since the last step
  int m_warn;
  int m_ss;
  int m_sel;

  display_select_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .DWELL_CYCLES   (DWELL),
    .LOW_MILES      (LOWM),
    .HYST           (HYS)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .btn_next       (btn_next),
    .Miles_remaining(miles),
    .SS             (SS),
    .sel_changed    (sel_changed),
    .low_fuel_warn  (low_fuel_warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_run = 0; m_pend = 0;
    m_page = 0; m_dwell = 0; m_warn = 0; m_ss = 0; m_sel = 0;
  endtask

  task automatic model_step(input int b, input int mi);
    int older;
    int adv;
    int new_ss;
    older = m_s2;
    m_s2  = m_s1;
    m_s1  = b;
    adv    = m_pend;
    m_pend = 0;
    if (older != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = older;
        m_run = 0;
        if (m_deb == 1) m_pend = 1;
      end
    end else begin
      m_run = 0;
    end
`ifdef AUTO_SCROLL_EN
    begin
      int expire;
      expire = (m_warn == 0 && m_dwell == DWELL - 1) ? 1 : 0;
      if (adv == 1 || expire == 1) m_dwell = 0;
      else if (m_warn == 0) m_dwell++;
      if (expire == 1) adv = 1;
    end
`endif
    m_page = (m_page + adv) % 4;
    if (mi < LOWM) m_warn = 1;
    else if (mi >= LOWM + HYS) m_warn = 0;
    new_ss = (m_warn == 1) ? 3 : m_page;
    m_sel  = (new_ss != m_ss) ? 1 : 0;
    m_ss   = new_ss;
  endtask

  // One clock: drive inputs, update model at the edge, compare mid-cycle.
  task automatic tick(input logic b, input logic [7:0] mi);
    btn_next = b;
    miles    = mi;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(int'(b), int'(mi));
    @(negedge clk);
    check("SS", int'(SS), m_ss);
    check("sel_changed", int'(sel_changed), m_sel);
    check("low_fuel_warn", int'(low_fuel_warn), m_warn);
  endtask

  task automatic press(input int hi, input int lo, input logic [7:0] mi);
    for (int i = 0; i < hi; i++) tick(1'b1, mi);
    for (int i = 0; i < lo; i++) tick(1'b0, mi);
  endtask

  initial begin
    int picks[8];
    logic [7:0] mv;
    picks = '{240, 25, 24, 20, 19, 15, 0, 255};
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    rst_n    = 1'b0;
    btn_next = 1'b0;
    miles    = 8'd240;

    // Reset state.
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'd240);
    check("reset_SS", int'(SS), 0);
    check("reset_sel", int'(sel_changed), 0);
    check("reset_warn", int'(low_fuel_warn), 0);
    rst_n = 1'b1;

    // Glitch shorter than the debounce window.
    press(3, 12, 8'd240);
`ifndef AUTO_SCROLL_EN
    check("glitch_SS", int'(SS), 0);
`endif

    // Held press: SS steps on the 7th edge, once.
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 8'd240);
`ifndef AUTO_SCROLL_EN
      if (i == 6) check("press_edge6_SS", int'(SS), 0);
      if (i == 7) begin
        check("press_edge7_SS", int'(SS), 1);
        check("press_edge7_sel", int'(sel_changed), 1);
      end
      if (i == 12) check("press_hold_SS", int'(SS), 1);
`endif
    end
    for (int i = 0; i < 10; i++) tick(1'b0, 8'd240);

    // Four clean presses (wraps back to the same page).
    for (int k = 0; k < 4; k++) press(10, 10, 8'd240);
`ifndef AUTO_SCROLL_EN
    check("wrap_SS", int'(SS), 1);
`endif

    // Low-fuel warning with hysteresis; a press during the warning.
    tick(1'b0, 8'd15);
    check("warn_set", int'(low_fuel_warn), 1);
    check("warn_SS", int'(SS), 3);
    for (int i = 0; i < 5; i++) tick(1'b0, 8'd22);
    check("warn_hold", int'(low_fuel_warn), 1);
    press(10, 10, 8'd22);
    tick(1'b0, 8'd24);
    check("warn_hold24", int'(low_fuel_warn), 1);
    tick(1'b0, 8'd25);
    check("warn_clear", int'(low_fuel_warn), 0);
`ifndef AUTO_SCROLL_EN
    check("warn_clear_SS", int'(SS), 2);
`endif

    // Idle period (auto-scroll steps every DWELL cycles when enabled).
    for (int i = 0; i < 100; i++) tick(1'b0, 8'd240);
`ifndef AUTO_SCROLL_EN
    check("idle_SS", int'(SS), 2);
`endif

    // Reset in the middle of a debounce run.
    for (int i = 0; i < 4; i++) tick(1'b1, 8'd240);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'd240);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick(1'b0, 8'd240);
    check("post_reset_SS", int'(SS), 0);

    // Randomized phase.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) mv = 8'(picks[$urandom_range(0, 7)]);
        else mv = 8'($urandom_range(0, 255));
      end else begin
        mv = miles;
      end
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        tick(1'(($urandom_range(0, 1))), mv);
        rst_n = 1'b1;
      end
      begin
        int len;
        logic lvl;
        len = int'($urandom_range(1, 14));
        lvl = 1'($urandom_range(0, 1));
        for (int j = 0; j < len; j++) tick(lvl, mv);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
